stream_arbiter: RTL and testbench

//  Packet-granular round-robin arbiter that shares the single 32-bit packet_handler ingress among NUM_SRC upstream sources.

---
 rtl/stream_arb_pkg.sv | 10 +
 rtl/rr_arbiter.sv | 17 +
 rtl/stream_arbiter.sv | 94 +++++++++
 tb/tb_stream_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_arb_pkg.sv
// stream_arb_pkg: shared state encoding and datapath constants for the stream arbiter
package stream_arb_pkg;
    localparam int WORD_W    = 32;
    localparam int HDR_WORDS = 2;
    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        XFER  = 3'b010,
        DRAIN = 3'b100
    } state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt
);
    logic [2*N-1:0] dbl, sel2;
    logic [N-1:0]   rot, first;
    // rotate so ptr sits at bit 0, isolate lowest set bit, rotate back
    assign dbl   = {req, req} >> ptr;
    assign rot   = dbl[N-1:0];
    assign first = rot & (~rot + N'(1));
    assign sel2  = {first, first} << ptr;
    assign gnt   = sel2[2*N-1:N];
endmodule

// File: rtl/stream_arbiter.sv
// stream_arbiter: packet-granular round-robin mux of NUM_SRC word streams into one
// handler ingress, truncating packets longer than MAX_WORDS and draining their tails.
module stream_arbiter
    import stream_arb_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int MAX_WORDS = 11
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [WORD_W*NUM_SRC-1:0] i_src_data,
    input  logic [NUM_SRC-1:0]        i_src_valid,
    input  logic [NUM_SRC-1:0]        i_src_last,
    output logic [NUM_SRC-1:0]        o_src_ready,
    output logic [WORD_W-1:0]         o_data,
    output logic                      o_valid,
    output logic                      o_last,
    input  logic                      i_ready,
    output logic [NUM_SRC-1:0]        o_grant,
    output logic                      o_trunc
);
    localparam int PTR_W = $clog2(NUM_SRC);
    localparam int CNT_W = $clog2(MAX_WORDS + 1);

    state_e             state_q;
    logic [NUM_SRC-1:0] grant_q, arb_gnt;
    logic [PTR_W-1:0]   ptr_q, idx_q, arb_idx, ptr_inc;
    logic [CNT_W-1:0]   cnt_q;
    logic               trunc_q, sel_valid, sel_last, at_max, xfer;

    rr_arbiter #(.N(NUM_SRC)) u_rr (
        .req(i_src_valid),
        .ptr(ptr_q),
        .gnt(arb_gnt)
    );

    always_comb begin
        arb_idx = '0;
        for (int k = 0; k < NUM_SRC; k++)
            if (arb_gnt[k]) arb_idx = PTR_W'(k);
    end

    assign sel_valid   = i_src_valid[idx_q];
    assign sel_last    = i_src_last[idx_q];
    assign at_max      = cnt_q == CNT_W'(MAX_WORDS - 1);
    assign ptr_inc     = idx_q == PTR_W'(NUM_SRC - 1) ? '0 : idx_q + 1'b1;
    assign o_data      = i_src_data[idx_q*WORD_W +: WORD_W];
    assign o_valid     = state_q == XFER && sel_valid;
    assign o_last      = state_q == XFER && (sel_last || at_max);
    // in DRAIN the tail is swallowed regardless of downstream backpressure
    assign o_src_ready = state_q == XFER  ? grant_q & {NUM_SRC{i_ready}} :
                         state_q == DRAIN ? grant_q : '0;
    assign xfer        = o_valid && i_ready;
    assign o_grant     = grant_q;
    assign o_trunc     = trunc_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            trunc_q <= 1'b0;
        end else begin
            trunc_q <= 1'b0;
            case (state_q)
                IDLE: if (|i_src_valid) begin
                    grant_q <= arb_gnt;
                    idx_q   <= arb_idx;
                    cnt_q   <= '0;
                    state_q <= XFER;
                end
                XFER: if (xfer) begin
                    cnt_q <= cnt_q + 1'b1;
                    if (sel_last) begin
                        ptr_q   <= ptr_inc;
                        grant_q <= '0;
                        state_q <= IDLE;
                    end else if (at_max) begin
                        trunc_q <= 1'b1;
                        state_q <= DRAIN;
                    end
                end
                DRAIN: if (sel_valid && sel_last) begin
                    ptr_q   <= ptr_inc;
                    grant_q <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stream_arbiter.sv
// tb_stream_arbiter: directed scenario tests for stream_arbiter with queued source packets
module tb_stream_arbiter;
    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [32*N-1:0] src_data;
    logic [N-1:0]    src_valid, src_last, src_ready, grant;
    logic [31:0]     data;
    logic            valid, last, ready, trunc;

    always #5 clk = ~clk;

    stream_arbiter #(.NUM_SRC(N), .MAX_WORDS(11)) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_src_data(src_data),
        .i_src_valid(src_valid),
        .i_src_last(src_last),
        .o_src_ready(src_ready),
        .o_data(data),
        .o_valid(valid),
        .o_last(last),
        .i_ready(ready),
        .o_grant(grant),
        .o_trunc(trunc)
    );

    int          total = 0, bad = 0, cyc = 0, n_trunc = 0;
    logic [31:0] w_mem[N][16];
    logic        l_mem[N][16];
    int          head[N], len[N];
    logic [31:0] log_d[$];
    logic        log_l[$];
    int          log_c[$];
    int          gnt_log[$];
    logic [N-1:0] prev_grant;
    bit          toggle, bp_chk;

    function automatic int gidx(input logic [N-1:0] g);
        int r = -1;
        for (int k = 0; k < N; k++) if (g[k]) r = k;
        return r;
    endfunction

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            src_valid[k] = head[k] < len[k];
            src_data[32*k +: 32] = src_valid[k] ? w_mem[k][head[k]] : 32'h0;
            src_last[k] = src_valid[k] && l_mem[k][head[k]];
        end
    endtask

    task automatic load(input int k, input logic [31:0] base, input int n);
        head[k] = 0;
        len[k] = n;
        for (int i = 0; i < n; i++) begin
            w_mem[k][i] = base + 32'(i);
            l_mem[k][i] = i == n - 1;
        end
    endtask

    task automatic clear_logs();
        log_d.delete();
        log_l.delete();
        log_c.delete();
        gnt_log.delete();
        n_trunc = 0;
    endtask

    // one clock: sample at negedge, pop consumed source words, drive next inputs after the edge
    task automatic step();
        logic [N-1:0] pop;
        @(negedge clk);
        if (valid && ready) begin
            log_d.push_back(data);
            log_l.push_back(last);
            log_c.push_back(cyc);
        end
        if (trunc) n_trunc++;
        if (grant != 0 && prev_grant == 0) gnt_log.push_back(gidx(grant));
        prev_grant = grant;
        total++;
        if ($countones(src_ready) > 1) begin
            bad++;
            $display("FAIL ready_onehot: got %b required at most one bit", src_ready);
        end
        if (bp_chk && grant[2] && valid) begin
            total++;
            if (src_ready[2] !== ready) begin
                bad++;
                $display("FAIL bp_ready_mirror: got %b required %b", src_ready[2], ready);
            end
        end
        pop = src_ready & src_valid;
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) if (pop[k]) head[k]++;
        if (toggle) ready = ~ready;
        drive();
        cyc++;
    endtask

    function automatic bit busy();
        bit b = grant != 0;
        for (int k = 0; k < N; k++) if (head[k] < len[k]) b = 1;
        return b;
    endfunction

    task automatic run(input int bound);
        int n = 0;
        while (busy() && n < bound) begin
            step();
            n++;
        end
        total++;
        if (n >= bound) begin
            bad++;
            $display("FAIL run_timeout: got %0d cycles required under %0d", n, bound);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        for (int k = 0; k < N; k++) begin
            head[k] = 0;
            len[k] = 0;
        end
        ready = 1'b1;
        toggle = 0;
        bp_chk = 0;
        drive();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        prev_grant = '0;
        clear_logs();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ready = 1'b1;
        toggle = 0;
        bp_chk = 0;
        for (int k = 0; k < N; k++) load(k, 32'(k), 1);
        drive();
        repeat (3) @(negedge clk);
        total++;
        if (grant !== '0 || valid !== 1'b0 || src_ready !== '0 || last !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: got grant=%b valid=%b ready=%b last=%b required 0", grant, valid, src_ready, last);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (grant !== 4'b0001) begin
            bad++;
            $display("FAIL reset_first_grant: got %b required 0001", grant);
        end
        do_reset();
    endtask

    task automatic test_rotation();
        clear_logs();
        for (int k = 0; k < N; k++) load(k, 32'(k << 8), 4);
        drive();
        run(100);
        total++;
        if (gnt_log.size() != 4 || gnt_log[0] != 0 || gnt_log[1] != 1 || gnt_log[2] != 2 || gnt_log[3] != 3) begin
            bad++;
            $display("FAIL rot_order: got %p required 0 1 2 3", gnt_log);
        end
        total++;
        if (log_d.size() != 16) begin
            bad++;
            $display("FAIL rot_count: got %0d required 16", log_d.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                total++;
                if (log_d[i] !== 32'(((i / 4) << 8) + i % 4) || log_l[i] !== (i % 4 == 3)) begin
                    bad++;
                    $display("FAIL rot_word%0d: got %h/%b required %h/%b", i, log_d[i], log_l[i], ((i / 4) << 8) + i % 4, i % 4 == 3);
                end
            end
            for (int p = 0; p < 3; p++) begin
                total++;
                if (log_c[4*p+4] - log_c[4*p+3] != 2) begin
                    bad++;
                    $display("FAIL rot_gap%0d: got %0d required 2", p, log_c[4*p+4] - log_c[4*p+3]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        clear_logs();
        load(2, 32'hA0, 6);
        ready = 1'b1;
        toggle = 1;
        bp_chk = 1;
        drive();
        run(60);
        toggle = 0;
        bp_chk = 0;
        ready = 1'b1;
        drive();
        total++;
        if (log_d.size() != 6 || gnt_log.size() != 1 || gnt_log[0] != 2) begin
            bad++;
            $display("FAIL bp_count: got words=%0d grants=%p required 6 / 2", log_d.size(), gnt_log);
        end else begin
            for (int i = 0; i < 6; i++) begin
                total++;
                if (log_d[i] !== 32'hA0 + 32'(i) || log_l[i] !== (i == 5)) begin
                    bad++;
                    $display("FAIL bp_word%0d: got %h/%b required %h/%b", i, log_d[i], log_l[i], 32'hA0 + 32'(i), i == 5);
                end
            end
        end
    endtask

    task automatic test_trunc();
        clear_logs();
        load(1, 32'h1100, 14);
        load(2, 32'h2200, 2);
        drive();
        run(100);
        total++;
        if (n_trunc != 1) begin
            bad++;
            $display("FAIL trunc_pulse: got %0d required 1", n_trunc);
        end
        total++;
        if (gnt_log.size() != 2 || gnt_log[0] != 1 || gnt_log[1] != 2) begin
            bad++;
            $display("FAIL trunc_order: got %p required 1 2", gnt_log);
        end
        total++;
        if (log_d.size() != 13 || head[1] != 14) begin
            bad++;
            $display("FAIL trunc_count: got words=%0d consumed=%0d required 13 / 14", log_d.size(), head[1]);
        end else begin
            for (int i = 0; i < 13; i++) begin
                logic [31:0] e;
                e = i < 11 ? 32'h1100 + 32'(i) : 32'h2200 + 32'(i - 11);
                total++;
                if (log_d[i] !== e || log_l[i] !== (i == 10 || i == 12)) begin
                    bad++;
                    $display("FAIL trunc_word%0d: got %h/%b required %h/%b", i, log_d[i], log_l[i], e, i == 10 || i == 12);
                end
            end
        end
    endtask

    task automatic test_exact_limit();
        clear_logs();
        load(0, 32'h0500, 11);
        drive();
        run(60);
        total++;
        if (n_trunc != 0) begin
            bad++;
            $display("FAIL exact_trunc: got %0d required 0", n_trunc);
        end
        total++;
        if (log_d.size() != 11) begin
            bad++;
            $display("FAIL exact_count: got %0d required 11", log_d.size());
        end else begin
            for (int i = 0; i < 11; i++) begin
                total++;
                if (log_d[i] !== 32'h0500 + 32'(i) || log_l[i] !== (i == 10)) begin
                    bad++;
                    $display("FAIL exact_word%0d: got %h/%b required %h/%b", i, log_d[i], log_l[i], 32'h0500 + 32'(i), i == 10);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        int n = 0;
        clear_logs();
        load(3, 32'h3600, 6);
        load(0, 32'h0600, 2);
        drive();
        while (log_d.size() < 3 && n < 20) begin
            step();
            n++;
        end
        total++;
        if (log_d.size() != 3 || gnt_log.size() != 1 || gnt_log[0] != 3) begin
            bad++;
            $display("FAIL mid_pre: got words=%0d grants=%p required 3 / 3", log_d.size(), gnt_log);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (grant !== '0 || valid !== 1'b0 || src_ready !== '0 || last !== 1'b0 || trunc !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_outputs: got grant=%b valid=%b ready=%b last=%b trunc=%b required 0", grant, valid, src_ready, last, trunc);
        end
        step();
        step();
        rst_n = 1'b1;
        prev_grant = '0;
        clear_logs();
        run(60);
        total++;
        if (gnt_log.size() != 2 || gnt_log[0] != 0 || gnt_log[1] != 3) begin
            bad++;
            $display("FAIL mid_regrant: got %p required 0 3", gnt_log);
        end
        total++;
        if (log_d.size() != 5 || log_d[0] !== 32'h0600 || log_d[2] !== 32'h3603) begin
            bad++;
            $display("FAIL mid_words: got %p required 0600 0601 3603 3604 3605", log_d);
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_backpressure();
        test_trunc();
        test_exact_limit();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
